mux2_arbiter: RTL and testbench
===============================

// Module: mux2_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 2:1 datapath mux between two requesters.
//  Each requester raises req, waits for gnt, drives its data, and pulses done to release.
//  The arbiter owns the mux select and forces a release after a bounded hold time.
//  The registered grant and mux output feed a single downstream consumer (shared bus/register load).
// PARAMETERS
//  WIDTH     8   data width of each requester port and of dOut
//  MAX_HOLD  16  max consecutive owned cycles before forced release; 0 = no limit
//  CNT_W     $clog2(MAX_HOLD+1)  hold-counter width (derived, do not override)
// PORTS
//  CLK      in   1      system clock, rising edge
//  RST      in   1      asynchronous, active-high reset
//  req0     in   1      requester 0 wants the mux; level, held until gnt0 seen
//  req1     in   1      requester 1 wants the mux
//  done0    in   1      requester 0 releases; sampled only while gnt0=1
//  done1    in   1      requester 1 releases; sampled only while gnt1=1
//  data0    in   WIDTH  requester 0 data
//  data1    in   WIDTH  requester 1 data
//  gnt0     out  1      registered grant to requester 0
//  gnt1     out  1      registered grant to requester 1
//  sel      out  1      registered mux select (0=data0, 1=data1); equals owner
//  dOut     out  WIDTH  mux output, combinational from sel/data
//  valid    out  1      gnt0|gnt1; dOut is meaningful only when high
//  timeout  out  1      one-cycle pulse when a grant is force-released
// BEHAVIOUR
//  Reset (async, immediate, also mid-grant): state=IDLE, gnt0=gnt1=0, sel=0, valid=0,
//   timeout=0, hold_cnt=0, last_owner=1 (so requester 0 wins the first tie).
//  States: IDLE, OWN0, OWN1. gnt0=(OWN0), gnt1=(OWN1); never both high.
//  IDLE: req0&req1 -> grant the requester != last_owner; single req -> that one;
//   none -> stay. Grant appears the cycle after req is sampled (1-cycle latency).
//  OWNx release when done_x=1, or req_x=0, or (MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1).
//   On release: last_owner<=x; if other req high -> OWN(other) next cycle (no bubble),
//   else IDLE. Else stay, hold_cnt+=1.
//  hold_cnt cleared on every state entry into OWNx; saturates, never wraps.
//  timeout=1 for the release cycle only if forced by hold limit and done_x=0, req_x=1.
//  done_x and req_x falling together = normal release, timeout=0.
//  done on non-owner and done in IDLE: ignored. Req drop before grant: no grant issued.
//  sel tracks owner; in IDLE sel keeps its last value (dOut stays stable, valid=0).
// STRUCTURE
//  Package mux_arb_pkg: typedef enum logic[1:0] {IDLE, OWN0, OWN1} arb_state_t.
//  One sub-module: Mux2_1 #(.WIDTH(WIDTH)) instance, port0=data0, port1=data1,
//   sel=sel, dOut=dOut. FSM, hold counter, last_owner in one always_ff with async RST.
// TESTING
//  1 RST high, pulse req0 -> after RST low, req0=1: gnt0=1 next cycle, sel=0, dOut=data0.
//  2 req0=req1=1 from IDLE after reset -> gnt0 first; done0 -> gnt1 next cycle, no idle
//    cycle; done1 with req0 still high -> gnt0 again (alternation).
//  3 MAX_HOLD=4, req1 held, never done1 -> gnt1 high exactly 4 cycles, timeout pulse 1
//    cycle on 4th, then IDLE; with req0 high too -> gnt0 follows directly.
//  4 gnt0 held, assert done1 and RST-free noise on req1 -> gnt0 unaffected until done0.
//  5 RST asserted mid-OWN1 (asynchronous, between edges) -> gnt1, valid drop at once;
//    after release, req0&req1 -> gnt0 wins (last_owner reset to 1).
//  6 Property: never gnt0&gnt1; sel==gnt1 whenever valid; dOut==(sel?data1:data0) always.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } arb_state_t;

   // A zero hold limit would otherwise yield a zero-width counter
   function automatic int hold_cnt_width(input int max_hold);
      return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
   endfunction

endpackage

// File: rtl/mux2_arbiter_mux2_1.sv
// Plain 2:1 datapath mux shared by the two requesters.
module Mux2_1 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] port0,
   input  logic [WIDTH-1:0] port1,
   input  logic             sel,
   output logic [WIDTH-1:0] dOut
);

   assign dOut = sel ? port1 : port0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin owner of a shared 2:1 mux with done-based release and a bounded
// hold time that force-releases a requester that keeps the mux too long.
module mux2_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req0,
   input  logic             req1,
   input  logic             done0,
   input  logic             done1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic [WIDTH-1:0] dOut,
   output logic             valid,
   output logic             timeout
);

   localparam int CNT_W = hold_cnt_width(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             last_owner_q, last_owner_d;
   logic             sel_q, sel_d;
   logic             own_req, own_done, other_req, hold_hit;

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      last_owner_d = last_owner_q;
      sel_d        = sel_q;
      timeout      = 1'b0;
      own_req      = (state_q == OWN1) ? req1  : req0;
      own_done     = (state_q == OWN1) ? done1 : done0;
      other_req    = (state_q == OWN1) ? req0  : req1;
      hold_hit     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

      case (state_q)
         IDLE: begin
            // Ties go to whoever did not own the mux last
            if (req0 && (!req1 || last_owner_q)) begin
               state_d    = OWN0;
               sel_d      = 1'b0;
               hold_cnt_d = '0;
            end else if (req1) begin
               state_d    = OWN1;
               sel_d      = 1'b1;
               hold_cnt_d = '0;
            end
         end
         OWN0, OWN1: begin
            if (own_done || !own_req || hold_hit) begin
               timeout      = hold_hit && own_req && !own_done;
               last_owner_d = (state_q == OWN1);
               if (other_req) begin
                  state_d    = (state_q == OWN1) ? OWN0 : OWN1;
                  sel_d      = (state_q == OWN0);
                  hold_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (hold_cnt_q != CNT_MAX) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // last_owner resets to 1 so requester 0 wins the first tie
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         hold_cnt_q   <= '0;
         last_owner_q <= 1'b1;
         sel_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         last_owner_q <= last_owner_d;
         sel_q        <= sel_d;
      end
   end

   assign gnt0  = (state_q == OWN0);
   assign gnt1  = (state_q == OWN1);
   assign sel   = sel_q;
   assign valid = gnt0 | gnt1;

   Mux2_1 #(.WIDTH(WIDTH)) u_mux (
      .port0 (data0),
      .port1 (data1),
      .sel   (sel_q),
      .dOut  (dOut)
   );

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed vector table, reset corner
// cases and randomized traffic against a cycle-level ownership model.
module tb_mux2_arbiter;

   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;
   localparam int NUM_VECS = 32;

   logic             CLK   = 1'b0;
   logic             RST   = 1'b1;
   logic             req0  = 1'b0;
   logic             req1  = 1'b0;
   logic             done0 = 1'b0;
   logic             done1 = 1'b0;
   logic [WIDTH-1:0] data0 = '0;
   logic [WIDTH-1:0] data1 = '0;
   logic             gnt0, gnt1, sel, valid, timeout;
   logic [WIDTH-1:0] dOut;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the mux (-1 = nobody), for how many cycles
   // so far, who released last, and where the select currently points.
   int   m_owner;
   int   m_held;
   int   m_last;
   logic m_sel;

   typedef struct packed {
      logic r0;
      logic r1;
      logic d0;
      logic d1;
      logic g0;
      logic g1;
      logic sel;
      logic to;
   } vec_t;

   vec_t vecs[NUM_VECS];

   mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .req0    (req0),
      .req1    (req1),
      .done0   (done0),
      .done1   (done1),
      .data0   (data0),
      .data1   (data1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .sel     (sel),
      .dOut    (dOut),
      .valid   (valid),
      .timeout (timeout)
   );

   always #5 CLK = ~CLK;

   function automatic void model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 1;
      m_sel   = 1'b0;
   endfunction

   function automatic void model_grant(input int who);
      m_owner = who;
      m_held  = 1;
      m_sel   = (who == 1);
   endfunction

   function automatic logic model_forced();
      return (MAX_HOLD != 0) && (m_owner >= 0) && (m_held >= MAX_HOLD);
   endfunction

   function automatic logic [4:0] model_flags();
      logic to;
      logic rq;
      logic dn;
      rq = (m_owner == 1) ? req1 : req0;
      dn = (m_owner == 1) ? done1 : done0;
      to = model_forced() && rq && !dn;
      return {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, to};
   endfunction

   function automatic void model_step();
      logic rq[2];
      logic dn[2];
      int   o;
      rq[0] = req0;
      rq[1] = req1;
      dn[0] = done0;
      dn[1] = done1;
      if (m_owner < 0) begin
         if (rq[0] && rq[1]) model_grant(1 - m_last);
         else if (rq[0])     model_grant(0);
         else if (rq[1])     model_grant(1);
      end else begin
         o = m_owner;
         if (dn[o] || !rq[o] || model_forced()) begin
            m_last = o;
            if (rq[1-o]) model_grant(1 - o);
            else         m_owner = -1;
         end else begin
            m_held++;
         end
      end
   endfunction

   task automatic applyStimulus(input logic r0, input logic r1, input logic d0, input logic d1);
      req0  = r0;
      req1  = r1;
      done0 = d0;
      done1 = d1;
      data0 = WIDTH'($urandom);
      data1 = WIDTH'($urandom);
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      if (RST) model_reset();
      else     model_step();
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [4:0] exp_flags,
                              input logic [WIDTH-1:0] exp_data);
      checks++;
      if ({gnt0, gnt1, sel, valid, timeout} !== exp_flags) begin
         errors++;
         $display("[TB] FAIL %s: {gnt0,gnt1,sel,valid,timeout} got %b expected %b",
                  name, {gnt0, gnt1, sel, valid, timeout}, exp_flags);
      end
      checks++;
      if (dOut !== exp_data) begin
         errors++;
         $display("[TB] FAIL %s: dOut got %h expected %h", name, dOut, exp_data);
      end
   endtask

   initial begin
      // Columns: req0 req1 done0 done1 | gnt0 gnt1 sel timeout (before the edge)
      vecs[0]  = 8'b1100_0000;
      vecs[1]  = 8'b1100_1000;
      vecs[2]  = 8'b1110_1000;
      vecs[3]  = 8'b1100_0110;
      vecs[4]  = 8'b1101_0110;
      vecs[5]  = 8'b1000_1000;
      vecs[6]  = 8'b0000_1000;
      vecs[7]  = 8'b0000_0000;
      vecs[8]  = 8'b0100_0000;
      vecs[9]  = 8'b0100_0110;
      vecs[10] = 8'b0100_0110;
      vecs[11] = 8'b0100_0110;
      vecs[12] = 8'b0100_0111;
      vecs[13] = 8'b0000_0010;
      vecs[14] = 8'b0100_0010;
      vecs[15] = 8'b1100_0110;
      vecs[16] = 8'b1100_0110;
      vecs[17] = 8'b1100_0110;
      vecs[18] = 8'b1100_0111;
      vecs[19] = 8'b1100_1000;
      vecs[20] = 8'b1100_1000;
      vecs[21] = 8'b1100_1000;
      vecs[22] = 8'b0010_1000;
      vecs[23] = 8'b0000_0000;
      vecs[24] = 8'b1000_0000;
      vecs[25] = 8'b1101_1000;
      vecs[26] = 8'b1001_1000;
      vecs[27] = 8'b1101_1000;
      vecs[28] = 8'b1110_1000;
      vecs[29] = 8'b0000_0110;
      vecs[30] = 8'b0011_0010;
      vecs[31] = 8'b0000_0010;

      model_reset();

      // Reset holds everything off even while req0 is raised
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_state", 5'b00000, data0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("req_during_reset", 5'b00000, data0);
      #2 RST = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("idle_after_reset", 5'b00000, data0);
      tick();
      checkOutput("first_grant", 5'b10010, data0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      RST = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      RST = 1'b0;
      checkOutput("post_reset", 5'b00000, data0);

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1);
         checkOutput($sformatf("vec%0d", i),
                     {vecs[i].g0, vecs[i].g1, vecs[i].sel, vecs[i].g0 | vecs[i].g1, vecs[i].to},
                     vecs[i].sel ? data1 : data0);
         tick();
      end

      // Asynchronous reset in the middle of an OWN1 cycle
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t5_idle", 5'b00100, data1);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t5_own1", 5'b01110, data1);
      #2 RST = 1'b1;
      #1;
      checkOutput("t5_async_reset", 5'b00000, data0);
      model_reset();
      tick();
      RST = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("t5_idle_after", 5'b00000, data0);
      tick();
      checkOutput("t5_tie_to_req0", 5'b10010, data0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 85,
                       $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15);
         checkOutput($sformatf("rand%0d", c), model_flags(), m_sel ? data1 : data0);
         checks++;
         if (gnt0 && gnt1) begin
            errors++;
            $display("[TB] FAIL rand%0d_exclusive: gnt0 %b gnt1 %b, expected at most one high",
                     c, gnt0, gnt1);
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
